// File: rtl/simmem_pkg.sv
// Shared defaults and bank state type for the simmem row-buffer timing model.
package simmem_pkg;

  localparam int unsigned DefaultAddrWidth         = 16;
  localparam int unsigned DefaultRowBufferLenWidth = 8;
  localparam int unsigned DefaultIDWidth           = 4;
  localparam int unsigned DefaultNumBanks          = 4;
  localparam int unsigned DefaultDelayWidth        = 8;

  localparam int unsigned DefaultRowHitCost     = 10;
  localparam int unsigned DefaultPrechargeCost  = 50;
  localparam int unsigned DefaultActivationCost = 45;

  // Cost values are carried wide enough that any combination of the three fits.
  localparam int unsigned CostWidth = 16;

  localparam int unsigned DefaultRowTagWidth =
    DefaultAddrWidth - DefaultRowBufferLenWidth - $clog2(DefaultNumBanks);

  typedef struct packed {
    logic                          open;
    logic [DefaultRowTagWidth-1:0] row;
    logic [DefaultDelayWidth-1:0]  busy;
  } bank_state_t;

endpackage

// File: rtl/simmem_bank_state.sv
// One DRAM bank: open/row tracking, busy countdown and access cost lookup.
// SIMMEM_CLOSED_PAGE_EN selects closed-page behaviour (bank never left open).
module simmem_bank_state
  import simmem_pkg::*;
#(
  parameter int unsigned RowTagWidth    = DefaultRowTagWidth,
  parameter int unsigned DelayWidth     = DefaultDelayWidth,
  parameter int unsigned RowHitCost     = DefaultRowHitCost,
  parameter int unsigned PrechargeCost  = DefaultPrechargeCost,
  parameter int unsigned ActivationCost = DefaultActivationCost
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [RowTagWidth-1:0] row_i,
  input  logic [DelayWidth-1:0]  busy_i,
  output logic [DelayWidth-1:0]  remain_o,
  output logic [CostWidth-1:0]   cost_o
);

  logic                   open_q, open_d;
  logic [RowTagWidth-1:0] row_q, row_d;
  logic [DelayWidth-1:0]  busy_q, busy_d;

  // Remaining busy time once this cycle has elapsed; also the idle next state.
  always_comb begin
    remain_o = (busy_q == '0) ? '0 : busy_q - DelayWidth'(1);
  end

  always_comb begin
`ifdef SIMMEM_CLOSED_PAGE_EN
    cost_o = CostWidth'(ActivationCost + RowHitCost);
`else
    if (!open_q) begin
      cost_o = CostWidth'(ActivationCost + RowHitCost);
    end else if (row_q == row_i) begin
      cost_o = CostWidth'(RowHitCost);
    end else begin
      cost_o = CostWidth'(PrechargeCost + ActivationCost + RowHitCost);
    end
`endif
  end

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    busy_d = remain_o;
    if (load_i) begin
`ifndef SIMMEM_CLOSED_PAGE_EN
      open_d = 1'b1;
`endif
      row_d  = row_i;
      busy_d = busy_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q <= 1'b0;
      row_q  <= '0;
      busy_q <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/simmem_row_model.sv
// DRAM row-buffer timing model: decodes requests, adds bank busy time to access
// cost and presents a saturated delay. Define SIMMEM_CLOSED_PAGE_EN for closed page.
module simmem_row_model
  import simmem_pkg::*;
#(
  parameter int unsigned NumBanks          = DefaultNumBanks,
  parameter int unsigned AddrWidth         = DefaultAddrWidth,
  parameter int unsigned RowBufferLenWidth = DefaultRowBufferLenWidth,
  parameter int unsigned RowHitCost        = DefaultRowHitCost,
  parameter int unsigned PrechargeCost     = DefaultPrechargeCost,
  parameter int unsigned ActivationCost    = DefaultActivationCost,
  parameter int unsigned DelayWidth        = DefaultDelayWidth,
  parameter int unsigned IDWidth           = DefaultIDWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [IDWidth-1:0]    in_id_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DelayWidth-1:0] out_delay_o,
  output logic [IDWidth-1:0]    out_id_o
);

  localparam int unsigned BankBits    = $clog2(NumBanks);
  localparam int unsigned RowTagWidth = AddrWidth - RowBufferLenWidth - BankBits;
  localparam int unsigned SumWidth    = 32;
  localparam logic [SumWidth-1:0] DelayMax = SumWidth'({DelayWidth{1'b1}});

  logic                   accept;
  logic [BankBits-1:0]    bankIdx;
  logic [RowTagWidth-1:0] rowTag;
  logic                   unusedOffset;
  logic [NumBanks-1:0]    bankLoad;
  logic [DelayWidth-1:0]  bankRemain [NumBanks];
  logic [CostWidth-1:0]   bankCost [NumBanks];
  logic [SumWidth-1:0]    sum;
  logic [DelayWidth-1:0]  delaySat;
  logic [DelayWidth-1:0]  busyLoad;

  logic                  outValid_q, outValid_d;
  logic [DelayWidth-1:0] outDelay_q, outDelay_d;
  logic [IDWidth-1:0]    outId_q, outId_d;

  // Byte offset within the row has no timing effect.
  assign unusedOffset = ^in_addr_i[RowBufferLenWidth-1:0];
  assign bankIdx      = in_addr_i[RowBufferLenWidth +: BankBits];
  assign rowTag       = in_addr_i[AddrWidth-1 -: RowTagWidth];

  assign in_ready_o = !outValid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  for (genvar b = 0; b < NumBanks; b++) begin : gBank
    assign bankLoad[b] = accept && (bankIdx == BankBits'(b));

    simmem_bank_state #(
      .RowTagWidth   (RowTagWidth),
      .DelayWidth    (DelayWidth),
      .RowHitCost    (RowHitCost),
      .PrechargeCost (PrechargeCost),
      .ActivationCost(ActivationCost)
    ) uBank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (bankLoad[b]),
      .row_i   (rowTag),
      .busy_i  (busyLoad),
      .remain_o(bankRemain[b]),
      .cost_o  (bankCost[b])
    );
  end

  assign sum      = SumWidth'(bankRemain[bankIdx]) + SumWidth'(bankCost[bankIdx]);
  assign delaySat = (sum > DelayMax) ? DelayMax[DelayWidth-1:0] : sum[DelayWidth-1:0];

  // Closed page keeps the bank busy for the auto-precharge that follows the access.
`ifdef SIMMEM_CLOSED_PAGE_EN
  logic [SumWidth-1:0] sumPre;
  assign sumPre   = sum + SumWidth'(PrechargeCost);
  assign busyLoad = (sumPre > DelayMax) ? DelayMax[DelayWidth-1:0] : sumPre[DelayWidth-1:0];
`else
  assign busyLoad = delaySat;
`endif

  always_comb begin
    outValid_d = outValid_q;
    outDelay_d = outDelay_q;
    outId_d    = outId_q;
    if (out_ready_i) begin
      outValid_d = 1'b0;
    end
    if (accept) begin
      outValid_d = 1'b1;
      outDelay_d = delaySat;
      outId_d    = in_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      outDelay_q <= '0;
      outId_q    <= '0;
    end else begin
      outValid_q <= outValid_d;
      outDelay_q <= outDelay_d;
      outId_q    <= outId_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_delay_o = outDelay_q;
  assign out_id_o    = outId_q;

endmodule

// File: tb/tb_simmem_row_model.sv
// Testbench for simmem_row_model: default and 6-bit-delay instances share stimulus
// and are checked against a timeline-based reference model (SIMMEM_CLOSED_PAGE_EN aware).
module tb_simmem_row_model;

  localparam int HitC = 10;
  localparam int PreC = 50;
  localparam int ActC = 45;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [15:0] inAddr = '0;
  logic [3:0]  inId = '0;
  logic        outReady = 1'b1;

  logic        inReadyA, inReadyB;
  logic        outValidA, outValidB;
  logic [7:0]  outDelayA;
  logic [5:0]  outDelayB;
  logic [3:0]  outIdA, outIdB;

  int errors = 0;
  int checks = 0;

  // Reference model: each bank is free again at absolute cycle busyEnd.
  int cyc = 0;
  bit expValid;
  int expId;
  int expDelay [2];
  int busyEnd [2][4];
  bit mOpen [2][4];
  int mRow [2][4];
  int maxDelay [2] = '{255, 63};

  logic [15:0] rAddr;

  always #5 clk = ~clk;

  simmem_row_model dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(inValid), .in_ready_o(inReadyA), .in_addr_i(inAddr), .in_id_i(inId),
    .out_valid_o(outValidA), .out_ready_i(outReady), .out_delay_o(outDelayA), .out_id_o(outIdA)
  );

  simmem_row_model #(.DelayWidth(6)) dutSat (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(inValid), .in_ready_o(inReadyB), .in_addr_i(inAddr), .in_id_i(inId),
    .out_valid_o(outValidB), .out_ready_i(outReady), .out_delay_o(outDelayB), .out_id_o(outIdB)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 4; b++) begin
        busyEnd[d][b] = 0;
        mOpen[d][b]   = 1'b0;
        mRow[d][b]    = 0;
      end
      expDelay[d] = 0;
    end
    expValid = 1'b0;
    expId    = 0;
  endtask

  task automatic modelAccept(input int d, input int addr);
    int bank;
    int row;
    int remain;
    int cost;
    int delay;
    int load;
    bank   = (addr >> 8) % 4;
    row    = addr >> 10;
    remain = (busyEnd[d][bank] > cyc) ? busyEnd[d][bank] - cyc : 0;
`ifdef SIMMEM_CLOSED_PAGE_EN
    cost = ActC + HitC;
`else
    if (!mOpen[d][bank]) cost = ActC + HitC;
    else if (mRow[d][bank] == row) cost = HitC;
    else cost = PreC + ActC + HitC;
`endif
    delay = (remain + cost > maxDelay[d]) ? maxDelay[d] : remain + cost;
`ifdef SIMMEM_CLOSED_PAGE_EN
    load = (delay + PreC > maxDelay[d]) ? maxDelay[d] : delay + PreC;
`else
    load = delay;
    mOpen[d][bank] = 1'b1;
`endif
    mRow[d][bank]    = row;
    busyEnd[d][bank] = cyc + load;
    expDelay[d]      = delay;
  endtask

  // One clock: drive at negedge, model the edge, check outputs at the next negedge.
  task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [3:0] id, input bit rdy);
    bit expReady;
    bit accept;
    inValid  = v;
    inAddr   = a;
    inId     = id;
    outReady = rdy;
    #1;
    expReady = !expValid || rdy;
    checkOutput("in_ready", int'(inReadyA), int'(expReady));
    checkOutput("in_ready_sat", int'(inReadyB), int'(expReady));
    accept = v && expReady;
    @(posedge clk);
    if (expValid && rdy) expValid = 1'b0;
    if (accept) begin
      modelAccept(0, int'(a));
      modelAccept(1, int'(a));
      expValid = 1'b1;
      expId    = int'(id);
    end
    cyc++;
    @(negedge clk);
    checkOutput("out_valid", int'(outValidA), int'(expValid));
    checkOutput("out_valid_sat", int'(outValidB), int'(expValid));
    if (expValid) begin
      checkOutput("out_delay", int'(outDelayA), expDelay[0]);
      checkOutput("out_delay_sat", int'(outDelayB), expDelay[1]);
      checkOutput("out_id", int'(outIdA), expId);
      checkOutput("out_id_sat", int'(outIdB), expId);
    end
  endtask

  task automatic applyReset();
    rst     = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    modelReset();
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_valid", int'(outValidA), 0);
    checkOutput("rst_valid_sat", int'(outValidB), 0);
    checkOutput("rst_delay", int'(outDelayA), 0);
    checkOutput("rst_id", int'(outIdA), 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    applyReset();

`ifndef SIMMEM_CLOSED_PAGE_EN
    applyStimulus(1'b1, 16'h0300, 4'h1, 1'b1);
    checkOutput("cold_access", int'(outDelayA), 55);
    idleCycles(60);
    applyStimulus(1'b1, 16'h0310, 4'h2, 1'b1);
    checkOutput("row_hit", int'(outDelayA), 10);
    idleCycles(20);
    applyStimulus(1'b1, 16'h0700, 4'h3, 1'b1);
    checkOutput("row_miss", int'(outDelayA), 105);
    checkOutput("row_miss_sat", int'(outDelayB), 63);
    idleCycles(2);

    applyStimulus(1'b1, 16'h0000, 4'h4, 1'b1);
    checkOutput("contend_first", int'(outDelayA), 55);
    applyStimulus(1'b1, 16'h0000, 4'h5, 1'b1);
    checkOutput("contend_second", int'(outDelayA), 64);
    applyStimulus(1'b1, 16'h0100, 4'h6, 1'b1);
    checkOutput("other_bank", int'(outDelayA), 55);
    idleCycles(1);

    applyStimulus(1'b1, 16'h0104, 4'h7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h0200, 4'h8, 1'b0);
      checkOutput("stall_in_ready", int'(inReadyA), 0);
      checkOutput("stall_id", int'(outIdA), 7);
    end
    applyStimulus(1'b1, 16'h0200, 4'h8, 1'b1);
    checkOutput("release_delay", int'(outDelayA), 55);
    checkOutput("release_id", int'(outIdA), 8);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1);

    applyStimulus(1'b1, 16'h0300, 4'h9, 1'b0);
    applyStimulus(1'b1, 16'h0300, 4'h9, 1'b0);
    applyReset();
    applyStimulus(1'b1, 16'h0700, 4'hA, 1'b1);
    checkOutput("post_reset_bank", int'(outDelayA), 55);
    checkOutput("post_reset_bank_sat", int'(outDelayB), 55);
`else
    applyStimulus(1'b1, 16'h0100, 4'h1, 1'b1);
    checkOutput("closed_first", int'(outDelayA), 55);
    applyStimulus(1'b1, 16'h0100, 4'h2, 1'b1);
    checkOutput("closed_second", int'(outDelayA), 159);
    checkOutput("closed_second_sat", int'(outDelayB), 63);
`endif

    idleCycles(3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyReset();
      end else begin
        rAddr = 16'(($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 255));
        applyStimulus($urandom_range(0, 3) != 0, rAddr, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 9) < 7);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simmem_row_model.md
SIMMEM_ROW_MODEL -- requirements
Module: simmem_row_model

Interface
REQ-001 SHALL have parameter NumBanks, default 4, number of modelled DRAM banks (power of two, >=2).
REQ-002 SHALL have parameter AddrWidth, default 16, request address width.
REQ-003 SHALL have parameter RowBufferLenWidth, default 8, log2 of row length in bytes.
REQ-004 SHALL have parameters RowHitCost=10, PrechargeCost=50, ActivationCost=45, all in cycles.
REQ-005 SHALL have parameter DelayWidth, default 8, width of delay output and per-bank busy counters.
REQ-006 SHALL have parameter IDWidth, default 4, width of the passthrough transaction id.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset (one clock; reset is synchronous and active-high).
REQ-008 SHALL have ports: in_valid_i in 1, in_ready_o out 1, in_addr_i in AddrWidth, in_id_i in IDWidth (request).
REQ-009 SHALL have ports: out_valid_o out 1, out_ready_i in 1, out_delay_o out DelayWidth, out_id_o out IDWidth (computed delay).

Function
REQ-010 SHALL decode: offset = addr[RowBufferLenWidth-1:0]; bank = next log2(NumBanks) bits; row tag = remaining upper bits.
REQ-011 SHALL keep per bank: open flag, open row tag, busy counter (DelayWidth bits).
REQ-012 SHALL compute cost: bank closed -> ActivationCost+RowHitCost; open, same row -> RowHitCost; open, other row -> PrechargeCost+ActivationCost+RowHitCost.
REQ-013 SHALL compute delay = busy counter of addressed bank (value in accept cycle) + cost, saturating at 2^DelayWidth-1.
REQ-014 SHALL accept a request when in_valid_i && in_ready_o; in_ready_o = !out_valid_o || out_ready_i.
REQ-015 SHALL register delay and id into a single output stage; out_valid_o rises the cycle after acceptance (latency 1).
REQ-016 SHALL hold out_delay_o/out_id_o stable while out_valid_o && !out_ready_i.
REQ-017 SHALL, on acceptance, set bank open flag, store row tag, load busy counter with the delay (REQ-013); load takes precedence over decrement.
REQ-018 SHALL decrement every non-zero busy counter by 1 per cycle when not loaded; zero stays zero.
REQ-019 SHALL permit pass-through: simultaneous out_ready_i handshake and new acceptance in one cycle, no bubble.
REQ-020 SHALL not alter bank state for requests not accepted.

Reset
REQ-021 SHALL, with rst_i high at a clock edge, clear all open flags, row tags, busy counters, out_valid_o, out_delay_o, out_id_o to 0.
REQ-022 SHALL drop any pending output on reset mid-operation; first post-reset access to any bank treated as closed.

Configuration
REQ-023 SHALL support macro SIMMEM_CLOSED_PAGE_EN.
REQ-024 SHALL, without SIMMEM_CLOSED_PAGE_EN, use open-page policy as in REQ-012/REQ-017.
REQ-025 SHALL, with SIMMEM_CLOSED_PAGE_EN, never set open flags; cost always ActivationCost+RowHitCost; busy counter loads delay+PrechargeCost (saturating), out_delay_o excludes PrechargeCost.

Structure
REQ-026 SHALL source default costs, AddrWidth, RowBufferLenWidth, IDWidth from simmem_pkg; add NumBanks default and a bank_state_t typedef (open, row, busy) there.
REQ-027 SHALL instantiate one sub-module simmem_bank_state per bank (state registers, counter, cost lookup); top holds decode, saturating add, output stage.

Verification
REQ-028 SHALL test cold access: after reset, addr 0x0300 (bank 3, row 0) -> out_delay_o=55 one cycle later.
REQ-029 SHALL test row hit: wait 60 idle cycles, addr 0x0310 -> delay 10; row miss: wait 20 idle cycles, addr 0x0700 -> delay 105.
REQ-030 SHALL test bank contention: cold bank 0 access, next cycle same row -> second delay 54+10=64; other bank same cycle stream -> unaffected 55.
REQ-031 SHALL test backpressure: out_ready_i low 5 cycles -> output stable, in_ready_o low, no bank state change; release -> one handshake.
REQ-032 SHALL test saturation: DelayWidth=6, row miss -> delay 63; reset mid-backpressure -> out_valid_o 0, next access to previously open bank -> 55.
REQ-033 SHALL test SIMMEM_CLOSED_PAGE_EN: two back-to-back same-row accesses bank 1 -> delays 55, then 54+50+55=159.
